// File: rtl/ff_match_extract_pkg.sv
// Shared types and constants for the match-extract stage behind the shift-or filter.
package ff_extract_pkg;

  localparam int BYTES_PER_WORD = 32;
  localparam int BUCKETS        = 8;
  localparam int REC_POS_W      = 16;

  typedef enum logic [1:0] {IDLE, SCAN, EOP} state_t;

  typedef struct packed {
    logic [REC_POS_W-1:0] pos;
    logic [BUCKETS-1:0]   buckets;
    logic                 eop;
  } cand_rec_t;

endpackage

// File: rtl/ff_match_extract_if.sv
// Filter-result input and candidate-record output stream of ff_match_extract.
interface ff_match_extract_if #(
  parameter int POS_W = 16
);
  logic [255:0]     in_data;
  logic             in_valid;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [POS_W-1:0] out_pos;
  logic [7:0]       out_buckets;
  logic             out_eop;
  logic             overflow;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  out_valid, out_pos, out_buckets, out_eop, overflow
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output out_valid, out_pos, out_buckets, out_eop, overflow
  );
endinterface

// File: rtl/ff_match_extract_fifo.sv
// Synchronous first-word fall-through FIFO holding {last, result word} entries.
module ff_word_fifo #(
  parameter int AW = 4,
  parameter int W  = 257
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/ff_match_extract.sv
// Buffers filter result words and serialises every matching byte lane into
// {offset, bucket vector} candidate records, closing each packet with an EOP record.
module ff_match_extract
  import ff_extract_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int POS_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ff_match_extract_if.slave  bus
);
  localparam int WORD_W = BYTES_PER_WORD * BUCKETS;
  localparam int WIDX_W = POS_W - 5;
  localparam logic [WIDX_W-1:0] WIDX_MAX = '1;

  function automatic logic [BYTES_PER_WORD-1:0] lanes_hit(input logic [WORD_W-1:0] d);
    logic [BYTES_PER_WORD-1:0] r;
    for (int unsigned k = 0; k < BYTES_PER_WORD; k++)
      r[k] = (d[k*BUCKETS +: BUCKETS] != '1);
    return r;
  endfunction

  function automatic logic [4:0] low_lane(input logic [BYTES_PER_WORD-1:0] v);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = BYTES_PER_WORD; i > 0; i--)
      if (v[i-1]) r = 5'(i - 1);
    return r;
  endfunction

  logic              full, empty, push, pop;
  logic [WORD_W:0]   head;
  state_t            state;
  logic [WORD_W-1:0] wdata;
  logic              wlast;
  logic [BYTES_PER_WORD-1:0] pend, pend_next;
  logic [WIDX_W-1:0] widx;
  logic [4:0]        low;
  logic              slot_free, word_done;
  cand_rec_t         rec;
  logic              rec_valid;
  logic              ovf;

  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign push = bus.in_valid && (!full || pop);

  ff_word_fifo #(.AW(FIFO_AW), .W(WORD_W + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({bus.in_last, bus.in_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // The word finishes in the same cycle its last pending lane is emitted,
  // which keeps throughput at max(1, matches) cycles per word.
  always_comb begin
    slot_free = !rec_valid || bus.out_ready;
    low       = low_lane(pend);
    pend_next = pend & ~(BYTES_PER_WORD'(1) << low);
    word_done = (pend == '0) || (slot_free && (pend_next == '0));
    pop       = 1'b0;
    unique case (state)
      IDLE:    pop = !empty;
      SCAN:    pop = !empty && word_done && !wlast;
      EOP:     pop = !empty && slot_free;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wdata     <= '0;
      wlast     <= 1'b0;
      pend      <= '0;
      widx      <= '0;
      rec       <= '0;
      rec_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (bus.in_valid && full && !pop) ovf <= 1'b1;
      if (rec_valid && bus.out_ready) rec_valid <= 1'b0;

      unique case (state)
        IDLE: if (pop) state <= SCAN;
        SCAN: begin
          if ((pend != '0) && slot_free) begin
            rec_valid   <= 1'b1;
            rec.pos     <= REC_POS_W'({widx, low});
            rec.buckets <= ~wdata[{low, 3'b000} +: BUCKETS];
            rec.eop     <= 1'b0;
            pend        <= pend_next;
          end
          if (word_done) begin
            if (wlast) begin
              state <= EOP;
            end else begin
              widx  <= (widx == WIDX_MAX) ? widx : widx + WIDX_W'(1);
              state <= pop ? SCAN : IDLE;
            end
          end
        end
        EOP: if (slot_free) begin
          rec_valid <= 1'b1;
          rec       <= '{pos: '0, buckets: '0, eop: 1'b1};
          widx      <= '0;
          state     <= pop ? SCAN : IDLE;
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        wdata <= head[WORD_W-1:0];
        wlast <= head[WORD_W];
        pend  <= lanes_hit(head[WORD_W-1:0]);
      end
    end
  end

  assign bus.out_valid   = rec_valid;
  assign bus.out_pos     = rec.pos[POS_W-1:0];
  assign bus.out_buckets = rec.buckets;
  assign bus.out_eop     = rec.eop;
  assign bus.overflow    = ovf;
endmodule
